// File: rtl/contador_pkg.sv
// Shared constants and the update-source type for the contador_entrada stimulus source.
package contador_pkg;
    localparam int LARGURA_ENTRADA        = 6;
    localparam int DEBOUNCE_CYCLES_PADRAO = 4;
    localparam int TICK_DIV_PADRAO        = 8;

    typedef enum logic [2:0] {
        NENHUM,
        CARGA,
        AUTO,
        INC,
        DEC
    } fonte_t;
endpackage

// File: rtl/debounce_botao.sv
// Raw push-button conditioner: 2-flop synchronizer, debounce counter, and a
// registered one-cycle pulse on each rising debounced level.
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic botao_i,
    output logic pulso_o
);
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          nivel_q;
    logic          nivel_d;
    logic          nivel_ant_q;
    logic          pulso_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The counter only runs while the synchronized value disagrees with the level.
    always_comb begin
        nivel_d = nivel_q;
        cnt_d   = '0;
        if (sync2_q != nivel_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                nivel_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            nivel_q     <= 1'b0;
            nivel_ant_q <= 1'b0;
            pulso_q     <= 1'b0;
        end else begin
            sync1_q     <= botao_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            nivel_q     <= nivel_d;
            nivel_ant_q <= nivel_q;
            pulso_q     <= nivel_q & ~nivel_ant_q;
        end
    end

    assign pulso_o = pulso_q;
endmodule

// File: rtl/contador_entrada.sv
// 6-bit operand source for the 7-segment stage: parallel load, auto-scan
// divider and debounced inc/dec buttons, resolved by a fixed priority.
module contador_entrada
    import contador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_PADRAO,
    parameter int TICK_DIV        = TICK_DIV_PADRAO,
    parameter int LARGURA         = LARGURA_ENTRADA
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_inc,
    input  logic               btn_dec,
    input  logic               carga,
    input  logic [LARGURA-1:0] valor_carga,
    input  logic               modo_auto,
    output logic [LARGURA-1:0] entrada,
    output logic               atualizado
);
    localparam int TW = $clog2(TICK_DIV);

    logic               pulso_inc;
    logic               pulso_dec;
    fonte_t             fonte;
    logic [TW-1:0]      tick_q;
    logic [TW-1:0]      tick_d;
    logic [LARGURA-1:0] entrada_q;
    logic [LARGURA-1:0] entrada_d;
    logic               atualizado_q;
    logic               atualizado_d;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .botao_i (btn_inc),
        .pulso_o (pulso_inc)
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
        .clk     (clk),
        .rst_n   (rst_n),
        .botao_i (btn_dec),
        .pulso_o (pulso_dec)
    );

    // Press pulses are single-cycle, so any source that wins over them discards them.
    always_comb begin
        fonte  = NENHUM;
        tick_d = '0;
        if (carga) begin
            fonte = CARGA;
        end else if (modo_auto) begin
            if (tick_q == TW'(TICK_DIV - 1)) begin
                fonte = AUTO;
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end else if (pulso_inc && !pulso_dec) begin
            fonte = INC;
        end else if (pulso_dec && !pulso_inc) begin
            fonte = DEC;
        end
    end

    always_comb begin
        entrada_d = entrada_q;
        case (fonte)
            CARGA:    entrada_d = valor_carga;
            AUTO,
            INC:      entrada_d = entrada_q + LARGURA'(1);
            DEC:      entrada_d = entrada_q - LARGURA'(1);
            default:  entrada_d = entrada_q;
        endcase
        atualizado_d = (fonte != NENHUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            entrada_q    <= '0;
            atualizado_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            entrada_q    <= entrada_d;
            atualizado_q <= atualizado_d;
        end
    end

    assign entrada    = entrada_q;
    assign atualizado = atualizado_q;
endmodule
